// File: rtl/sad_acc_pe.sv
// sad_acc_pe: streaming saturating SAD accumulator with best-candidate tracking.
// Revision: 1.0
`default_nettype none

module sad_acc_pe #(
  parameter int               PIX_W     = 8,
  parameter int               ACC_W     = 16,
  parameter logic [ACC_W-1:0] THRESHOLD = 16'd500,
  parameter int               WIN_LEN   = 64,
  parameter int               NUM_CAND  = 16,
  parameter int               IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_t,
  input  logic [PIX_W-1:0] in_i,
  output logic             busy,
  output logic             sad_valid,
  output logic [ACC_W-1:0] sad_out,
  output logic [IDX_W-1:0] sad_idx,
  output logic             sad_sat,
  output logic [ACC_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             done
);

  localparam int PCNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [PCNT_W-1:0] PIX_LAST  = PCNT_W'(WIN_LEN - 1);
  localparam logic [IDX_W-1:0]  CAND_LAST = IDX_W'(NUM_CAND - 1);

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PCNT_W-1:0] pix_q, pix_d;
  logic [IDX_W-1:0]  cand_q, cand_d;
  logic              sad_valid_q, sad_valid_d;
  logic [ACC_W-1:0]  sad_out_q, sad_out_d;
  logic [IDX_W-1:0]  sad_idx_q, sad_idx_d;
  logic              sad_sat_q, sad_sat_d;
  logic [ACC_W-1:0]  best_sad_q, best_sad_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic              done_q, done_d;

  logic [PIX_W-1:0]  w_diff;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_next;

  // One spare bit on the sum so the compare against the ceiling never wraps.
  assign w_diff = (in_t >= in_i) ? (in_t - in_i) : (in_i - in_t);
  assign w_sum  = {1'b0, acc_q} + (ACC_W+1)'(w_diff);
  assign w_next = (w_sum < {1'b0, THRESHOLD}) ? w_sum[ACC_W-1:0] : THRESHOLD;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    acc_d       = acc_q;
    pix_d       = pix_q;
    cand_d      = cand_q;
    sad_valid_d = 1'b0;
    sad_out_d   = sad_out_q;
    sad_idx_d   = sad_idx_q;
    sad_sat_d   = sad_sat_q;
    best_sad_d  = best_sad_q;
    best_idx_d  = best_idx_q;
    done_d      = 1'b0;

    if (start) begin
      state_d    = S_ACCUM;
      busy_d     = 1'b1;
      acc_d      = '0;
      pix_d      = '0;
      cand_d     = '0;
      best_sad_d = THRESHOLD;
      best_idx_d = '0;
    end else if (state_q == S_ACCUM && in_valid) begin
      if (pix_q == PIX_LAST) begin
        sad_valid_d = 1'b1;
        sad_out_d   = w_next;
        sad_idx_d   = cand_q;
        sad_sat_d   = (w_next == THRESHOLD);
        if (w_next < best_sad_q) begin
          best_sad_d = w_next;
          best_idx_d = cand_q;
        end
        acc_d  = '0;
        pix_d  = '0;
        cand_d = cand_q + IDX_W'(1);
        if (cand_q == CAND_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end else begin
        acc_d = w_next;
        pix_d = pix_q + PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      pix_q       <= '0;
      cand_q      <= '0;
      sad_valid_q <= 1'b0;
      sad_out_q   <= '0;
      sad_idx_q   <= '0;
      sad_sat_q   <= 1'b0;
      best_sad_q  <= THRESHOLD;
      best_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      acc_q       <= acc_d;
      pix_q       <= pix_d;
      cand_q      <= cand_d;
      sad_valid_q <= sad_valid_d;
      sad_out_q   <= sad_out_d;
      sad_idx_q   <= sad_idx_d;
      sad_sat_q   <= sad_sat_d;
      best_sad_q  <= best_sad_d;
      best_idx_q  <= best_idx_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign sad_valid = sad_valid_q;
  assign sad_out   = sad_out_q;
  assign sad_idx   = sad_idx_q;
  assign sad_sat   = sad_sat_q;
  assign best_sad  = best_sad_q;
  assign best_idx  = best_idx_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sad_acc_pe.sv
// tb_sad_acc_pe: table vectors, directed corner sequences and random traffic vs a reference model.
// Revision: 1.0
`default_nettype none

module tb_sad_acc_pe;

  localparam int PIX_W    = 8;
  localparam int ACC_W    = 16;
  localparam int THR      = 500;
  localparam int WIN_LEN  = 4;
  localparam int NUM_CAND = 3;
  localparam int IDX_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [PIX_W-1:0] in_t = '0;
  logic [PIX_W-1:0] in_i = '0;
  logic             busy, sad_valid, sad_sat, done;
  logic [ACC_W-1:0] sad_out, best_sad;
  logic [IDX_W-1:0] sad_idx, best_idx;

  sad_acc_pe #(
    .PIX_W(PIX_W), .ACC_W(ACC_W), .THRESHOLD(16'd500),
    .WIN_LEN(WIN_LEN), .NUM_CAND(NUM_CAND), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_t(in_t), .in_i(in_i), .busy(busy), .sad_valid(sad_valid),
    .sad_out(sad_out), .sad_idx(sad_idx), .sad_sat(sad_sat),
    .best_sad(best_sad), .best_idx(best_idx), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a search is a list of windows, each window a list of |t-i|.
  bit m_busy, m_sv, m_sat, m_done;
  int m_sad, m_idx, m_best, m_bidx, m_cand;
  int win_q[$];

  task automatic model_reset();
    m_busy = 0; m_sv = 0; m_sat = 0; m_done = 0;
    m_sad = 0; m_idx = 0; m_best = THR; m_bidx = 0; m_cand = 0;
    win_q.delete();
  endtask

  task automatic model_step(input bit r, s, v, input int t, i);
    int total;
    if (r) begin
      model_reset();
      return;
    end
    m_sv = 0;
    m_done = 0;
    if (s) begin
      m_busy = 1; m_cand = 0; m_best = THR; m_bidx = 0;
      win_q.delete();
    end else if (m_busy && v) begin
      win_q.push_back((t > i) ? t - i : i - t);
      if (win_q.size() == WIN_LEN) begin
        total = 0;
        foreach (win_q[k]) total += win_q[k];
        m_sad = (total < THR) ? total : THR;
        m_idx = m_cand;
        m_sat = (m_sad == THR);
        m_sv  = 1;
        if (m_sad < m_best) begin
          m_best = m_sad;
          m_bidx = m_cand;
        end
        win_q.delete();
        if (m_cand == NUM_CAND - 1) begin
          m_busy = 0;
          m_done = 1;
        end
        m_cand++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("busy", int'(busy), int'(m_busy));
    chk("sad_valid", int'(sad_valid), int'(m_sv));
    chk("sad_out", int'(sad_out), m_sad);
    chk("sad_idx", int'(sad_idx), m_idx);
    chk("sad_sat", int'(sad_sat), int'(m_sat));
    chk("best_sad", int'(best_sad), m_best);
    chk("best_idx", int'(best_idx), m_bidx);
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic step(input bit r, s, v, input int t, i);
    @(negedge clk);
    rst = r; start = s; in_valid = v;
    in_t = PIX_W'(t); in_i = PIX_W'(i);
    @(posedge clk);
    #1;
    model_step(r, s, v, t, i);
    chk_model();
  endtask

  typedef struct {
    bit s, v;
    int t, i;
    bit sv;
    int sad, idx;
    bit sat;
    int best, bidx;
    bit dn, bsy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Three windows of one search: normal, saturating, then restart from zero.
    tbl[0]  = '{1, 0,   0, 0, 0,   0, 0, 0, 500, 0, 0, 1};
    tbl[1]  = '{0, 1,  10, 3, 0,   0, 0, 0, 500, 0, 0, 1};
    tbl[2]  = '{0, 1,   3,10, 0,   0, 0, 0, 500, 0, 0, 1};
    tbl[3]  = '{0, 1,   0, 0, 0,   0, 0, 0, 500, 0, 0, 1};
    tbl[4]  = '{0, 1, 255, 0, 1, 269, 0, 0, 269, 0, 0, 1};
    tbl[5]  = '{0, 1, 255, 0, 0, 269, 0, 0, 269, 0, 0, 1};
    tbl[6]  = '{0, 1, 255, 0, 0, 269, 0, 0, 269, 0, 0, 1};
    tbl[7]  = '{0, 1, 255, 0, 0, 269, 0, 0, 269, 0, 0, 1};
    tbl[8]  = '{0, 1, 255, 0, 1, 500, 1, 1, 269, 0, 0, 1};
    tbl[9]  = '{0, 1,   1, 0, 0, 500, 1, 1, 269, 0, 0, 1};
    tbl[10] = '{0, 1,   1, 0, 0, 500, 1, 1, 269, 0, 0, 1};
    tbl[11] = '{0, 1,   1, 0, 0, 500, 1, 1, 269, 0, 0, 1};
    tbl[12] = '{0, 1,   1, 0, 1,   4, 2, 0,   4, 2, 1, 0};

    model_reset();

    // Reset held two cycles with random inputs.
    for (int k = 0; k < 2; k++)
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255));
    chk("rst_best_sad", int'(best_sad), 500);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sad_out", int'(sad_out), 0);

    for (int k = 0; k < 13; k++) begin
      step(0, tbl[k].s, tbl[k].v, tbl[k].t, tbl[k].i);
      chk("tbl_sad_valid", int'(sad_valid), int'(tbl[k].sv));
      chk("tbl_sad_out", int'(sad_out), tbl[k].sad);
      chk("tbl_sad_idx", int'(sad_idx), tbl[k].idx);
      chk("tbl_sad_sat", int'(sad_sat), int'(tbl[k].sat));
      chk("tbl_best_sad", int'(best_sad), tbl[k].best);
      chk("tbl_best_idx", int'(best_idx), tbl[k].bidx);
      chk("tbl_done", int'(done), int'(tbl[k].dn));
      chk("tbl_busy", int'(busy), int'(tbl[k].bsy));
    end

    // In DONE: stray pixels change nothing; results hold.
    for (int k = 0; k < 5; k++) step(0, 0, 1, 9, 0);
    chk("done_hold_best", int'(best_sad), 4);
    chk("done_hold_sv", int'(sad_valid), 0);

    // Best tracking: window SADs 300, 120, 120 -> tie keeps index 1.
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 75, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 30);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 30, 0);
    chk("best_tie_sad", int'(best_sad), 120);
    chk("best_tie_idx", int'(best_idx), 1);
    chk("best_tie_done", int'(done), 1);

    // Abort after one pixel, then start coinciding with a pixel (dropped).
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 200, 0);
    step(0, 1, 1, 200, 0);
    chk("abort_no_sv", int'(sad_valid), 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 5, 0);
    chk("abort_sad", int'(sad_out), 20);
    chk("abort_idx", int'(sad_idx), 0);

    // Reset mid-window.
    step(0, 0, 1, 7, 0);
    step(1, 0, 1, 7, 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_best", int'(best_sad), 500);
    chk("midrst_sad", int'(sad_out), 0);
    step(0, 0, 1, 7, 0);
    chk("idle_no_sv", int'(sad_valid), 0);

    // Random traffic with gaps, restarts and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      bit r, s, v;
      r = ($urandom_range(0, 599) == 0);
      s = m_busy ? ($urandom_range(0, 119) == 0) : ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, s, v, $urandom_range(0, 255), $urandom_range(0, 255));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sad_acc_pe.md
# sad_acc_pe

Parametrised, streaming sum-of-absolute-differences processing element for the SAD template-matching array. It accumulates saturating |template − image| over a window of `WIN_LEN` multi-bit pixel pairs and emits one SAD per candidate position. It tracks the minimum SAD and its candidate index across `NUM_CAND` candidates, and signals completion of the search. It succeeds the single-bit XOR/saturate PE: wider pixels, true absolute difference, internal window sequencing and best-match selection.

## Interface
- `PIX_W`, 8, pixel width in bits
- `ACC_W`, 16, accumulator/SAD width in bits
- `THRESHOLD`, 16'd500, saturation ceiling; must be < 2^ACC_W
- `WIN_LEN`, 64, pixel pairs per candidate window (≥1)
- `NUM_CAND`, 16, candidates per search (≥1)
- `IDX_W`, 8, candidate index width; 2^IDX_W ≥ NUM_CAND
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst` in 1: reset, synchronous and active-high
- `start` in 1: begin new search (single-cycle pulse)
- `in_valid` in 1: pixel pair present this cycle; no backpressure, always accepted while busy
- `in_t` in PIX_W: template pixel
- `in_i` in PIX_W: image pixel
- `busy` out 1: search in progress (state ACCUM)
- `sad_valid` out 1: one-cycle pulse, `sad_out`/`sad_idx`/`sad_sat` valid
- `sad_out` out ACC_W: completed window SAD
- `sad_idx` out IDX_W: candidate index of `sad_out`
- `sad_sat` out 1: `sad_out` hit THRESHOLD
- `best_sad` out ACC_W: minimum SAD so far in current search
- `best_idx` out IDX_W: candidate index of `best_sad`
- `done` out 1: one-cycle pulse, search finished

## Operation
- States: IDLE, ACCUM, DONE. Reset → IDLE.
- IDLE/DONE: `start` → ACCUM. Clear acc, pixel counter, candidate counter, `best_idx` to 0. Set `best_sad` to THRESHOLD. `in_valid` ignored.
- ACCUM: each `in_valid` cycle:
  - diff = |in_t − in_i| as unsigned PIX_W bits.
  - sum = acc + diff in ACC_W+1 bits.
  - next = (sum < THRESHOLD) ? sum : THRESHOLD. Accumulator never exceeds THRESHOLD; once saturated it stays saturated for the rest of the window.
  - The pixel counter increments.
- Window end (the `in_valid` cycle with pixel count = WIN_LEN−1), at that edge:
  - `sad_out` <= next; `sad_idx` <= cand count; `sad_sat` <= (next == THRESHOLD); `sad_valid` pulses.
  - If next < `best_sad` (strict; ties keep the earlier index): `best_sad` <= next, `best_idx` <= cand count.
  - acc <= 0, pixel count <= 0, cand count += 1.
  - If cand count == NUM_CAND−1: go to DONE and pulse `done` (same cycle as the final `sad_valid`).
- `in_valid` low in ACCUM: all state holds; gaps are legal anywhere in a window.
- `start` in ACCUM: abort the current search and restart as from IDLE. The partial window is discarded with no `sad_valid`. `start` has priority over a same-cycle `in_valid`; that pixel is dropped.
- `best_sad`/`best_idx` hold after DONE until next `start` or `rst`.
- `rst` mid-search: immediate return to IDLE on next edge; no pulses.

## Timing
- Reset values: `busy`=0, `sad_valid`=0, `sad_out`=0, `sad_idx`=0, `sad_sat`=0, `best_sad`=THRESHOLD, `best_idx`=0, `done`=0.
- All outputs registered.
- `busy` rises the cycle after `start`.
- Latency: the last pixel of a window sampled at edge N → `sad_valid`=1 during cycle N+1, updated `best_*` visible in cycle N+1.
- The first pixel of the next window may arrive in the cycle immediately after the last pixel of the previous window; throughput is 1 pixel/cycle with no bubbles.
- `sad_valid`/`done` high exactly one cycle; `busy` falls in the same cycle `done` is high.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs at reset values, `best_sad`=500, `busy`=0.
- Single window (WIN_LEN=4, NUM_CAND=1): `start`, pairs (10,3),(3,10),(0,0),(255,0) back-to-back → `sad_valid` one cycle after 4th pair, `sad_out`=269, `sad_idx`=0, `sad_sat`=0, `best_sad`=269, `done` same cycle, `busy` low.
- Saturation (THRESHOLD=500, WIN_LEN=4): four pairs (255,0) → `sad_out`=500, `sad_sat`=1. Next window (1,0)×4 → `sad_out`=4, acc restarted from 0.
- Best tracking (WIN_LEN=2, NUM_CAND=3): window SADs 300, 120, 120 → `best_sad`=120, `best_idx`=1 (tie keeps earlier), `sad_idx` 0,1,2, `done` with third `sad_valid`.
- Gaps and abort: pixels with random `in_valid` gaps give the same SAD as back-to-back. `start` after 1 of 4 pixels → no `sad_valid`, following full window reports `sad_idx`=0 with only post-restart pixels counted. `start` together with `in_valid` → that pixel excluded.
- DONE/IDLE idle: `in_valid` pulses while IDLE or DONE → no output change, no `sad_valid`. `rst` mid-window → outputs at reset values next cycle.
